// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice datapath.
// Holds the envelope state encoding and sample/level constants.
package synth_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } env_state_t;

  localparam logic [7:0] SAMPLE_MID = 8'd128;
  localparam logic [7:0] LEVEL_MAX  = 8'd255;

endpackage

// File: rtl/tick_divider.sv
// Envelope rate divider: tick pulses once every RATE_DIV clocks.
// Ports: clk, reset (sync, active-low), tick (1-cycle pulse).
module tick_divider #(
  parameter int RATE_DIV = 256
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/adsr_envelope.sv
// Gate-driven ADSR envelope applied to an unsigned oscillator stream.
// Ports: clk, reset (sync, active-low), gate, attack/decay/release
//   steps, sustain_level, sample_in -> sample_out, env_level,
//   state, active.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int RATE_DIV = 256,
  parameter int SAMPLE_W = 8,
  parameter int ENV_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gate,
  input  logic [ENV_W-1:0]    attack_step,
  input  logic [ENV_W-1:0]    decay_step,
  input  logic [ENV_W-1:0]    sustain_level,
  input  logic [ENV_W-1:0]    release_step,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic [ENV_W-1:0]    env_level,
  output logic [2:0]          state,
  output logic                active
);

  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(SAMPLE_MID);
  localparam logic [ENV_W-1:0]    TOP = ENV_W'(LEVEL_MAX);
  localparam int PW = SAMPLE_W + ENV_W + 1;

  logic       tick;
  logic       gate_q;
  logic       rise;
  env_state_t st_q;

  logic        [ENV_W:0]   att_sum;
  logic signed [ENV_W+1:0] dec_diff;
  logic signed [ENV_W+1:0] sus_ext;

  logic signed [SAMPLE_W:0] d;
  logic signed [PW-1:0]     p;

  tick_divider #(
    .RATE_DIV(RATE_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign rise = gate & ~gate_q;

  assign att_sum  = {1'b0, env_level} + {1'b0, attack_step};
  assign dec_diff = $signed({2'b00, env_level})
                  - $signed({2'b00, decay_step});
  assign sus_ext  = $signed({2'b00, sustain_level});

  // Retrigger and gate-off take a cycle of their own; the level
  // only moves on ticks that are not also a transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q      <= S_IDLE;
      env_level <= '0;
      gate_q    <= 1'b0;
      active    <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        st_q   <= S_ATTACK;
        active <= 1'b1;
      end else if (!gate && (st_q == S_ATTACK ||
                             st_q == S_DECAY  ||
                             st_q == S_SUSTAIN)) begin
        st_q   <= S_RELEASE;
        active <= 1'b1;
      end else if (tick) begin
        unique case (st_q)
          S_IDLE: begin
            env_level <= '0;
          end
          S_ATTACK: begin
            if (att_sum >= {1'b0, TOP}) begin
              env_level <= TOP;
              st_q      <= S_DECAY;
            end else begin
              env_level <= att_sum[ENV_W-1:0];
            end
          end
          S_DECAY: begin
            if (dec_diff <= sus_ext) begin
              env_level <= sustain_level;
              st_q      <= S_SUSTAIN;
            end else begin
              env_level <= dec_diff[ENV_W-1:0];
            end
          end
          S_SUSTAIN: begin
            env_level <= sustain_level;
          end
          S_RELEASE: begin
            if (env_level <= release_step) begin
              env_level <= '0;
              st_q      <= S_IDLE;
              active    <= 1'b0;
            end else begin
              env_level <= env_level - release_step;
            end
          end
          default: begin
            env_level <= '0;
            st_q      <= S_IDLE;
            active    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st_q;

  // Offset-binary to signed, scale by level/256, back to offset.
  // Result stays within 0..254, so the low bits of the floor
  // shift are enough.
  assign d = $signed({1'b0, sample_in}) - $signed({1'b0, MID});
  assign p = d * $signed({1'b0, env_level});

  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_out <= MID;
    end else begin
      sample_out <= MID + p[SAMPLE_W+ENV_W-1:ENV_W];
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope (RATE_DIV=4).
// Directed scenarios plus random phase against a behavioural model.
module tb_adsr_envelope;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       gate;
  logic [7:0] attack_step;
  logic [7:0] decay_step;
  logic [7:0] sustain_level;
  logic [7:0] release_step;
  logic [7:0] sample_in;
  logic [7:0] sample_out;
  logic [7:0] env_level;
  logic [2:0] state;
  logic       active;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state (plain integers).
  int m_level = 0;
  int m_state = 0;
  int m_cnt   = 0;
  int m_gq    = 0;
  int m_out   = 128;
  bit rand_in = 1'b1;

  always #5 clk = ~clk;

  adsr_envelope #(
    .RATE_DIV(RD),
    .SAMPLE_W(8),
    .ENV_W   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .env_level    (env_level),
    .state        (state),
    .active       (active)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int nl, ns, nc, ng, no, diff;
    bit tk;
    if (rand_in) sample_in = 8'($urandom);
    tk = (m_cnt == RD - 1);
    nl = m_level;
    ns = m_state;
    no = 128 + (((int'(sample_in) - 128) * m_level) >>> 8);
    if (!reset) begin
      nl = 0; ns = 0; nc = 0; ng = 0; no = 128;
    end else begin
      nc = (m_cnt + 1) % RD;
      ng = int'(gate);
      if (gate && m_gq == 0) begin
        ns = 1;
      end else if (!gate && m_state >= 1 && m_state <= 3) begin
        ns = 4;
      end else if (tk) begin
        case (m_state)
          0: nl = 0;
          1: begin
            nl = m_level + int'(attack_step);
            if (nl >= 255) begin nl = 255; ns = 2; end
          end
          2: begin
            diff = m_level - int'(decay_step);
            if (diff <= int'(sustain_level)) begin
              nl = int'(sustain_level); ns = 3;
            end else nl = diff;
          end
          3: nl = int'(sustain_level);
          4: begin
            nl = m_level - int'(release_step);
            if (nl <= 0) begin nl = 0; ns = 0; end
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    m_level = nl; m_state = ns; m_cnt = nc; m_gq = ng; m_out = no;
    chk("env_level", int'(env_level), m_level);
    chk("state", int'(state), m_state);
    chk("active", int'(active), int'(m_state != 0));
    chk("sample_out", int'(sample_out), m_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_state(input int s, input int budget);
    int k = 0;
    while (m_state != s && k < budget) begin
      step();
      k++;
    end
    if (m_state != s) begin
      n_vec++;
      n_bad++;
      $error("FAIL wait_state: model state %0d want %0d", m_state, s);
    end
  endtask

  task automatic run_until_level(input int lv, input int budget);
    int k = 0;
    while (m_level != lv && k < budget) begin
      step();
      k++;
    end
    if (m_level != lv) begin
      n_vec++;
      n_bad++;
      $error("FAIL wait_level: model level %0d want %0d", m_level, lv);
    end
  endtask

  initial begin
    int held;
    reset = 1'b0; gate = 1'b1;
    attack_step = 8'd64; decay_step = 8'd32;
    sustain_level = 8'd200; release_step = 8'd100;
    sample_in = 8'd128;

    // Reset held with gate high.
    run(2);
    chk("rst_out", int'(sample_out), 128);
    chk("rst_env", int'(env_level), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_active", int'(active), 0);
    reset = 1'b1;
    step();
    chk("attack_entry", int'(state), 1);

    // Attack to peak, decay to sustain.
    run_until_state(2, 40);
    chk("attack_peak", int'(env_level), 255);
    run_until_state(3, 40);
    chk("sustain_lvl", int'(env_level), 200);
    sustain_level = 8'd150;
    run(RD);
    chk("sustain_live", int'(env_level), 150);

    // Scaling at fixed levels.
    rand_in = 1'b0;
    sustain_level = 8'd255;
    run(RD);
    sample_in = 8'd255; step();
    chk("scale_255_hi", int'(sample_out), 254);
    sample_in = 8'd0; step();
    chk("scale_255_lo", int'(sample_out), 0);
    sample_in = 8'd128; step();
    chk("scale_255_mid", int'(sample_out), 128);
    sustain_level = 8'd128;
    sample_in = 8'd255;
    run(RD);
    step();
    chk("scale_128_hi", int'(sample_out), 191);
    sustain_level = 8'd0;
    run(RD);
    rand_in = 1'b1;
    run(3);
    chk("scale_0", int'(sample_out), 128);

    // Release from 200.
    sustain_level = 8'd200;
    run(RD);
    gate = 1'b0;
    step();
    chk("release_entry", int'(state), 4);
    run_until_state(0, 40);
    chk("release_idle_lvl", int'(env_level), 0);
    chk("release_idle_act", int'(active), 0);

    // Retrigger during release at level 100.
    gate = 1'b1;
    run_until_state(3, 80);
    gate = 1'b0;
    run_until_level(100, 40);
    gate = 1'b1;
    step();
    chk("retrig_state", int'(state), 1);
    chk("retrig_hold", int'(env_level), 100);
    run(RD);
    chk("retrig_attack", int'(env_level), 164);

    // Rise coincident with a tick.
    gate = 1'b0;
    step();
    while (m_cnt != RD - 1) step();
    held = m_level;
    gate = 1'b1;
    step();
    chk("rise_tick_hold", int'(env_level), held);

    // Reset mid-note during sustain.
    run_until_state(3, 80);
    reset = 1'b0;
    step();
    chk("midrst_out", int'(sample_out), 128);
    chk("midrst_state", int'(state), 0);
    reset = 1'b1;

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      if ($urandom_range(0, 15) == 0) attack_step = 8'($urandom);
      if ($urandom_range(0, 15) == 0) decay_step = 8'($urandom);
      if ($urandom_range(0, 15) == 0) sustain_level = 8'($urandom);
      if ($urandom_range(0, 15) == 0)
        release_step = 8'($urandom_range(0, 60));
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
